// File: rtl/video_pkg.sv
// Shared constants for the TS line-buffer path.
//   TS_DW      default pixel width
//   TS_AW      default line address width (2^TS_AW pixels per line)
//   BANK_IW    width of a bank index (up to 4 banks)
//   next_bank  bank index successor with wrap at nbank
package video_pkg;

    localparam int TS_DW   = 8;
    localparam int TS_AW   = 9;
    localparam int BANK_IW = 2;

    typedef logic [BANK_IW-1:0] bank_idx_t;

    function automatic bank_idx_t next_bank(input bank_idx_t idx, input int nbank);
        if (int'(idx) == nbank - 1)
            return bank_idx_t'(0);
        else
            return bank_idx_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Ports:
//   i_clk                      clock
//   i_wr_en/i_wr_addr/i_wr_data write port
//   i_rd_en/i_rd_addr          read request; o_rd_data updates on the next edge
//   o_rd_data                  registered read data, holds when i_rd_en=0
module dpram #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 9
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [ADDRWIDTH-1:0] i_wr_addr,
    input  logic [DATAWIDTH-1:0] i_wr_data,
    input  logic                 i_rd_en,
    input  logic [ADDRWIDTH-1:0] i_rd_addr,
    output logic [DATAWIDTH-1:0] o_rd_data
);

    logic [DATAWIDTH-1:0] r_mem [2**ADDRWIDTH];
    logic [DATAWIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_wr_en)
            r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en)
            r_q <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_q;

endmodule

// File: rtl/video_tsline_bank.sv
// One line bank: pixel RAM plus per-pixel occupancy flops.
// The occupancy bit masks stale RAM contents, so reading a pixel clears it
// without ever writing zero back into the RAM.
// Ports:
//   i_clk, i_res                   clock, synchronous active-high reset
//   i_wr_sel                       this bank is the current write bank
//   i_wr_en/addr/data/prio         write request (prio: only fill empty pixels)
//   i_rd_sel                       this bank is the current read bank
//   i_rd_en/i_rd_addr              read-and-clear request
//   o_rd_data                      masked read data, valid the cycle after a read
//   o_prio_drop                    a priority write was rejected this cycle
module video_tsline_bank
    import video_pkg::*;
#(
    parameter int DW     = TS_DW,
    parameter int AW     = TS_AW,
    parameter int TRANSP = 1
) (
    input  logic          i_clk,
    input  logic          i_res,
    input  logic          i_wr_sel,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_wr_prio,
    input  logic          i_rd_sel,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    output logic          o_prio_drop
);

    logic [2**AW-1:0] r_occ;
    logic             r_hit;
    logic             w_opaque;
    logic             w_wr_try;
    logic             w_wr_acc;
    logic             w_rd;
    logic [DW-1:0]    w_q;

    assign w_opaque    = (TRANSP == 0) || (i_wr_data != '0);
    assign w_wr_try    = i_wr_sel && i_wr_en && w_opaque;
    assign w_wr_acc    = w_wr_try && (!i_wr_prio || !r_occ[i_wr_addr]);
    // Transparent writes are discarded before priority is considered, so
    // they never count as drops.
    assign o_prio_drop = w_wr_try && i_wr_prio && r_occ[i_wr_addr];
    assign w_rd        = i_rd_sel && i_rd_en;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_occ <= '0;
            r_hit <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_occ[i_wr_addr] <= 1'b1;
            // Read and write roles never share a bank, so these never collide.
            if (w_rd) begin
                r_occ[i_rd_addr] <= 1'b0;
                r_hit            <= r_occ[i_rd_addr];
            end
        end
    end

    dpram #(
        .DATAWIDTH (DW),
        .ADDRWIDTH (AW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_rd),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (w_q)
    );

    // r_hit and the RAM output register only move on a read of this bank,
    // so the masked value holds between reads.
    assign o_rd_data = r_hit ? w_q : '0;

endmodule

// File: rtl/video_tsline_buf.sv
// N-bank rotating line buffer for the TS overlay path.
// The write bank advances on every line_start; the read bank is always the
// next one after it (the oldest line), so reads lag writes by NBANK-1 lines.
// Ports:
//   i_clk, i_res       clock, synchronous active-high reset
//   i_line_start       rotate banks, clear prio drop counter
//   i_wr_*             pixel write into the write bank
//   i_rd_en/i_rd_addr  read-and-clear from the read bank
//   o_rd_data          read pixel (0 if empty), holds between reads
//   o_rd_valid         high the cycle after i_rd_en
//   o_wr_bank          current write bank index
//   o_rd_bank          current read bank index
//   o_prio_drops       saturating count of priority rejections this line
module video_tsline_buf
    import video_pkg::*;
#(
    parameter int DW     = TS_DW,
    parameter int AW     = TS_AW,
    parameter int NBANK  = 2,
    parameter int TRANSP = 1
) (
    input  logic          i_clk,
    input  logic          i_res,
    input  logic          i_line_start,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_wr_prio,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_valid,
    output logic [1:0]    o_wr_bank,
    output logic [1:0]    o_rd_bank,
    output logic [15:0]   o_prio_drops
);

    bank_idx_t     r_wr_bank;
    bank_idx_t     w_rd_bank;
    bank_idx_t     r_rd_src;
    logic          r_rd_valid;
    logic [15:0]   r_drops;
    logic [DW-1:0] w_bank_q [4];
    logic [3:0]    w_drop;

    assign w_rd_bank = next_bank(r_wr_bank, NBANK);

    // Always four slots so a 2-bit index never runs off the array; unused
    // slots read as zero and never drop.
    for (genvar g = 0; g < 4; g++) begin : g_bank
        if (g < NBANK) begin : g_used
            video_tsline_bank #(
                .DW     (DW),
                .AW     (AW),
                .TRANSP (TRANSP)
            ) u_bank (
                .i_clk       (i_clk),
                .i_res       (i_res),
                .i_wr_sel    (r_wr_bank == bank_idx_t'(g)),
                .i_wr_en     (i_wr_en),
                .i_wr_addr   (i_wr_addr),
                .i_wr_data   (i_wr_data),
                .i_wr_prio   (i_wr_prio),
                .i_rd_sel    (w_rd_bank == bank_idx_t'(g)),
                .i_rd_en     (i_rd_en),
                .i_rd_addr   (i_rd_addr),
                .o_rd_data   (w_bank_q[g]),
                .o_prio_drop (w_drop[g])
            );
        end else begin : g_unused
            assign w_bank_q[g] = '0;
            assign w_drop[g]   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_wr_bank  <= '0;
            r_rd_src   <= '0;
            r_rd_valid <= 1'b0;
            r_drops    <= '0;
        end else begin
            r_rd_valid <= i_rd_en;
            // Remember which bank served the read; roles may rotate meanwhile.
            if (i_rd_en)
                r_rd_src <= w_rd_bank;
            if (i_line_start) begin
                r_wr_bank <= next_bank(r_wr_bank, NBANK);
                r_drops   <= '0;
            end else if ((|w_drop) && (r_drops != 16'hFFFF)) begin
                r_drops <= r_drops + 16'd1;
            end
        end
    end

    assign o_rd_data    = w_bank_q[r_rd_src];
    assign o_rd_valid   = r_rd_valid;
    assign o_wr_bank    = r_wr_bank;
    assign o_rd_bank    = w_rd_bank;
    assign o_prio_drops = r_drops;

endmodule

// File: tb/tb_video_tsline_buf.sv
module tb_video_tsline_buf;

    logic        clk = 1'b0;
    logic        res, line_start, wr_en, wr_prio, rd_en;
    logic [8:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rdat [2];
    logic        rval [2];
    logic [1:0]  wbk  [2];
    logic [1:0]  rbk  [2];
    logic [15:0] drops[2];

    always #5 clk = ~clk;

    // Instance 0: two banks, transparent zero. Instance 1: three banks, opaque zero.
    video_tsline_buf #(.DW(8), .AW(9), .NBANK(2), .TRANSP(1)) dut0 (
        .i_clk(clk), .i_res(res), .i_line_start(line_start),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_prio(wr_prio),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rdat[0]), .o_rd_valid(rval[0]), .o_wr_bank(wbk[0]),
        .o_rd_bank(rbk[0]), .o_prio_drops(drops[0]));

    video_tsline_buf #(.DW(8), .AW(9), .NBANK(3), .TRANSP(0)) dut1 (
        .i_clk(clk), .i_res(res), .i_line_start(line_start),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_prio(wr_prio),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rdat[1]), .o_rd_valid(rval[1]), .o_wr_bank(wbk[1]),
        .o_rd_bank(rbk[1]), .o_prio_drops(drops[1]));

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model of both instances
    int        nb [2] = '{2, 3};
    int        tr [2] = '{1, 0};
    bit [7:0]  m_ram [2][4][512];
    bit        m_occ [2][4][512];
    int        m_wb  [2];
    int        m_drops [2];
    logic [7:0] last [2];
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input bit rs, input bit le, input bit we, input int wa,
                        input logic [7:0] wd, input bit wp, input bit re, input int ra);
        logic [7:0] e;
        int rb;
        res = rs; line_start = le; wr_en = we; wr_addr = 9'(wa); wr_data = wd;
        wr_prio = wp; rd_en = re; rd_addr = 9'(ra);
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                for (int b = 0; b < 4; b++)
                    for (int a = 0; a < 512; a++) m_occ[i][b][a] = 1'b0;
                m_wb[i] = 0; m_drops[i] = 0;
            end else begin
                rb = (m_wb[i] + 1) % nb[i];
                if (re) begin
                    e = m_occ[i][rb][ra] ? m_ram[i][rb][ra] : 8'h00;
                    if (i == 0) sb0.push_back(e); else sb1.push_back(e);
                    m_occ[i][rb][ra] = 1'b0;
                end
                if (we && !(tr[i] == 1 && wd == 8'h00)) begin
                    if (!wp || !m_occ[i][m_wb[i]][wa]) begin
                        m_ram[i][m_wb[i]][wa] = wd;
                        m_occ[i][m_wb[i]][wa] = 1'b1;
                    end else if (!le && m_drops[i] != 65535) begin
                        m_drops[i] = m_drops[i] + 1;
                    end
                end
                if (le) begin
                    m_wb[i] = (m_wb[i] + 1) % nb[i];
                    m_drops[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("wr_bank%0d", i), 32'(wbk[i]), 32'(m_wb[i]));
            chk($sformatf("rd_bank%0d", i), 32'(rbk[i]), 32'((m_wb[i] + 1) % nb[i]));
            chk($sformatf("prio_drops%0d", i), 32'(drops[i]), 32'(m_drops[i]));
            chk($sformatf("rd_valid%0d", i), 32'(rval[i]), 32'(re && !rs));
            if (rs) last[i] = 8'h00;
            if (re && !rs) begin
                if (i == 0) begin
                    if (sb0.size() > 0) e = sb0.pop_front(); else e = 8'hxx;
                end else begin
                    if (sb1.size() > 0) e = sb1.pop_front(); else e = 8'hxx;
                end
                last[i] = e;
            end
            chk($sformatf("rd_data%0d", i), 32'(rdat[i]), 32'(last[i]));
        end
    endtask

    // shorthands
    task automatic idle();                   step(0,0,0,0,8'h00,0,0,0); endtask
    task automatic ls();                     step(0,1,0,0,8'h00,0,0,0); endtask
    task automatic wr(input int a, input logic [7:0] d, input bit p); step(0,0,1,a,d,p,0,0); endtask
    task automatic rd(input int a);          step(0,0,0,0,8'h00,0,1,a); endtask
    task automatic rst();                    step(1,0,0,0,8'h00,0,0,0); endtask

    initial begin
        res = 1'b1; line_start = 0; wr_en = 0; wr_prio = 0; rd_en = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        last[0] = 8'h00; last[1] = 8'h00;

        // Reset state
        rst(); rst();
        chk("rst_wr_bank", 32'(wbk[0]), 0);
        chk("rst_rd_bank", 32'(rbk[0]), 1);
        chk("rst_rd_bank3", 32'(rbk[1]), 1);
        chk("rst_rd_valid", 32'(rval[0]), 0);
        chk("rst_rd_data", 32'(rdat[0]), 0);

        // Basic read-back
        wr(10, 8'h5A, 0);
        ls();
        rd(10);
        chk("basic_rd", 32'(rdat[0]), 32'h5A);
        ls();
        rd(10);
        chk("basic_cleared", 32'(rdat[0]), 0);

        // Priority mode
        wr(3, 8'h11, 1);
        wr(3, 8'h22, 1);
        chk("prio_drops", 32'(drops[0]), 1);
        chk("prio_drops3", 32'(drops[1]), 1);
        ls();
        chk("prio_drops_clr", 32'(drops[0]), 0);
        rd(3);
        chk("prio_first_wins", 32'(rdat[0]), 32'h11);
        wr(3, 8'h11, 0);
        wr(3, 8'h22, 0);
        ls();
        rd(3);
        chk("overwrite", 32'(rdat[0]), 32'h22);

        // Transparency (dut0 skips zero, dut1 writes it)
        rst();
        wr(5, 8'h33, 0);
        wr(5, 8'h00, 0);
        ls();
        rd(5);
        chk("transp_keep", 32'(rdat[0]), 32'h33);
        ls();
        rd(5);
        chk("opaque_zero", 32'(rdat[1]), 0);

        // Three-bank latency and wrap
        rst();
        for (int a = 0; a < 4; a++) wr(20 + a, 8'(8'hA1 + a), 0);
        ls();
        chk("wb3_1", 32'(wbk[1]), 1);
        for (int a = 0; a < 4; a++) wr(20 + a, 8'(8'hB1 + a), 0);
        ls();
        chk("wb3_2", 32'(wbk[1]), 2);
        chk("rb3_0", 32'(rbk[1]), 0);
        for (int a = 0; a < 4; a++) begin
            rd(20 + a);
            chk("lat3_lineA", 32'(rdat[1]), 32'(8'hA1 + a));
        end
        ls();
        chk("wb3_wrap", 32'(wbk[1]), 0);
        for (int a = 0; a < 4; a++) begin
            rd(20 + a);
            chk("lat3_lineB", 32'(rdat[1]), 32'(8'hB1 + a));
        end

        // Write coinciding with line_start; prio drop coinciding with line_start
        rst();
        step(0,1,1,7,8'h77,0,0,0);
        rd(7);
        chk("coinc_wr2", 32'(rdat[0]), 32'h77);
        ls();
        rd(7);
        chk("coinc_wr3", 32'(rdat[1]), 32'h77);
        wr(8, 8'h01, 0);
        step(0,1,1,8,8'h02,1,0,0);
        chk("coinc_drop", 32'(drops[0]), 0);

        // Boundary addresses
        wr(0, 8'hC0, 0);
        wr(511, 8'hCF, 0);
        ls();
        rd(0);
        rd(511);
        chk("addr_max", 32'(rdat[0]), 32'hCF);

        // Mid-line reset, with a read pending on the reset cycle
        for (int a = 0; a < 16; a++) wr(a, 8'(a + 1), 0);
        ls();
        for (int a = 0; a < 16; a++) wr(a, 8'(a + 1), 0);
        step(1,0,0,0,8'h00,0,1,3);
        chk("mrst_valid", 32'(rval[0]), 0);
        chk("mrst_wb", 32'(wbk[0]), 0);
        chk("mrst_rb", 32'(rbk[0]), 1);
        for (int l = 0; l < 3; l++) begin
            for (int a = 0; a < 16; a++) begin
                rd(a);
                chk("mrst_empty0", 32'(rdat[0]), 0);
                chk("mrst_empty1", 32'(rdat[1]), 0);
            end
            ls();
        end

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                 ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15));
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/video_tsline_buf.md
# video_tsline_buf

Parametrised N-bank rotating line buffer for the TS (tile/sprite) overlay path. It sits between the TS renderer (write side) and the pixel renderer (read side). It generalises the fixed two-bank clear-on-read scheme to NBANK banks, configurable pixel width and line depth, transparent-pixel skipping and a first-opaque-wins priority mode. Read-back clearing uses per-pixel occupancy bits, so the pixel RAM never needs a zero-write pass.

## Interface
Parameters:
- DW, 8: pixel data width.
- AW, 9: line address width (2^AW pixels per line).
- NBANK, 2: number of line banks; legal range 2..4.
- TRANSP, 1: if 1, writes with wr_data==0 are discarded.

Ports:
- clk  in  1  system clock; the only clock.
- res  in  1  reset; synchronous, active-high.
- line_start  in  1  single-cycle pulse; rotates the banks.
- wr_en  in  1  pixel write strobe.
- wr_addr  in  AW  write pixel address.
- wr_data  in  DW  write pixel value.
- wr_prio  in  1  0 = overwrite; 1 = write only if the pixel is still empty.
- rd_en  in  1  read strobe; also clears the pixel it reads.
- rd_addr  in  AW  read pixel address.
- rd_data  out  DW  read pixel value; 0 if the pixel is empty.
- rd_valid  out  1  rd_data qualifier.
- wr_bank  out  2  current write bank index.
- rd_bank  out  2  current read bank index.
- prio_drops  out  16  saturating count of wr_prio rejections in the current line.

## Operation
- Each bank has a DW x 2^AW dual-port RAM and a 2^AW-bit occupancy vector held in flops.
- Bank roles:
  - The write bank is wr_bank.
  - The read bank is rd_bank = (wr_bank+1) mod NBANK, the oldest bank.
  - Read data therefore lags write data by NBANK-1 lines.
  - The read bank and write bank are never the same.
- Write acceptance: a write is accepted when wr_en=1, the value is not transparent (TRANSP=0 or wr_data!=0), and either wr_prio=0 or occ[wr_bank][wr_addr]=0.
- On an accepted write: the RAM word is written and occ[wr_bank][wr_addr]<=1.
- On a wr_prio rejection: prio_drops increments, saturating at 16'hFFFF.
- Read: when rd_en=1:
  - rd_data <= occ[rd_bank][rd_addr] ? ram[rd_bank][rd_addr] : 0.
  - occ[rd_bank][rd_addr] <= 0 in the same cycle.
- Rotation on line_start:
  - wr_bank <= (wr_bank+1) mod NBANK.
  - rd_bank follows wr_bank.
  - prio_drops <= 0.
  - The bank that becomes the write bank is the one just scanned by the reader.
- Pixels the reader never addressed stay occupied and reappear NBANK lines later. Clearing is therefore the reader's duty: it must scan the whole active width.

## Timing
- Reset values: wr_bank=0, rd_bank=1, rd_data=0, rd_valid=0, prio_drops=0.
- Reset clears all occupancy bits in one cycle. RAM contents are not reset; they are masked by occupancy.
- Read latency is 1 cycle: rd_valid=1 and rd_data appear in the cycle after rd_en; rd_valid=0 otherwise. rd_data holds its value when rd_valid=0.
- Write takes effect at the clock edge. A read of the same address in the same bank is impossible, because the banks are distinct.
- line_start coinciding with wr_en or rd_en: the access uses the pre-rotation bank indices, and the new roles apply from the next cycle.
- line_start coinciding with a wr_prio rejection: prio_drops becomes 0; the drop is not counted.
- res coinciding with anything: reset wins, and pending reads produce no rd_valid.
- Back-to-back reads and writes are supported every cycle. There are no stalls and no back-pressure.
- Bank index wrap uses mod NBANK arithmetic; for NBANK=3 the sequence is 0,1,2,0.

## Structure
- Package video_pkg holds the TS_DW and TS_AW defaults and the bank-index width constant (2 bits).
- Sub-module video_tsline_bank is one bank:
  - the dpram instance, using the existing ADDRWIDTH-parameterised dpram;
  - the occupancy vector;
  - the write-accept logic;
  - the masked read output.
- The top module instantiates NBANK of these, plus the rotation counter, the port muxing by role, and prio_drops.

## Test plan
- Basic read-back:
  - Stimulus: reset; write 0x5A at addr 10, line_start, rd_en addr 10.
  - Required response: next cycle rd_valid=1 and rd_data=0x5A.
  - Repeat the read on the following line: rd_data=0.
- Priority mode:
  - Stimulus: write 0x11 at addr 3 with wr_prio=1, then write 0x22 at addr 3 with wr_prio=1.
  - Required response: prio_drops=1; after rotation the read returns 0x11.
  - Same sequence with wr_prio=0: read returns 0x22.
- Transparency:
  - Stimulus: TRANSP=1, write 0x00 over existing 0x33.
  - Required response: read returns 0x33. With TRANSP=0 the read returns 0.
- Three-bank latency:
  - Stimulus: NBANK=3; write line A, line_start, write line B, line_start.
  - Required response: the reader now sees line A; wr_bank walks 0,1,2,0.
- Simultaneous events:
  - Stimulus: wr_en and line_start in the same cycle at addr 7.
  - Required response: data lands in the old write bank and is readable after NBANK-1 more rotations.
- Mid-line reset:
  - Stimulus: fill a bank, assert res.
  - Required response: every subsequent read returns 0, wr_bank=0, rd_bank=1.
